// File: rtl/pattern_resp_compactor.sv
// rtl/pattern_resp_compactor.sv - windowed MISR signature and stuck-bit compactor for pattern responses
//
// Captures one RESP_W-bit response vector per resp_valid cycle over a window of
// SAMPLES vectors. It folds the vectors into a SIG_W-bit MISR and tracks which
// response bits never toggled. Both results are then offered on a valid/ready port.
//
// Ports:
//   blif_clk_net    in   clock, rising edge
//   blif_reset_net  in   synchronous active-high reset
//   start           in   begin a window (IDLE only)
//   resp_in         in   response vector, G42_1 at bit 0
//   resp_valid      in   resp_in qualifier
//   busy            out  window running or result held
//   sample_cnt      out  vectors accepted in the current window
//   sig_out         out  MISR register
//   stuck_mask      out  1 = bit never toggled in the window (valid with sig_valid)
//   sig_valid       out  result available
//   sig_ready       in   result consumed
module pattern_resp_compactor #(
  parameter int                RESP_W  = 9,
  parameter int                SIG_W   = 16,
  parameter logic [SIG_W-1:0]  POLY    = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED    = 16'h0000,
  parameter int                SAMPLES = 256,
  localparam int               CW      = $clog2(SAMPLES + 1)
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic [RESP_W-1:0] resp_in,
  input  logic              resp_valid,
  output logic              busy,
  output logic [CW-1:0]     sample_cnt,
  output logic [SIG_W-1:0]  sig_out,
  output logic [RESP_W-1:0] stuck_mask,
  output logic              sig_valid,
  input  logic              sig_ready
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t            state;
  logic [RESP_W-1:0] prev;
  logic [RESP_W-1:0] toggled;

  logic [SIG_W-1:0]  sig_next;
  logic [RESP_W-1:0] toggled_next;
  logic              last_vec;

  always_comb begin
    sig_next     = {sig_out[SIG_W-2:0], 1'b0} ^ (sig_out[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp_in);
    // The first vector of a window has no predecessor, so it cannot toggle anything.
    toggled_next = (sample_cnt == '0) ? toggled : (toggled | (resp_in ^ prev));
    last_vec     = (sample_cnt == CW'(SAMPLES - 1));
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state      <= IDLE;
      busy       <= 1'b0;
      sig_valid  <= 1'b0;
      sample_cnt <= '0;
      sig_out    <= '0;
      stuck_mask <= '0;
      prev       <= '0;
      toggled    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            sig_out    <= SEED;
            sample_cnt <= '0;
            toggled    <= '0;
          end
        end
        RUN: begin
          if (resp_valid) begin
            sig_out    <= sig_next;
            sample_cnt <= sample_cnt + CW'(1);
            prev       <= resp_in;
            toggled    <= toggled_next;
            // The final vector's toggle is folded into the mask on the same edge.
            if (last_vec) begin
              state      <= HOLD;
              sig_valid  <= 1'b1;
              stuck_mask <= ~toggled_next;
            end
          end
        end
        HOLD: begin
          if (sig_ready) begin
            state     <= IDLE;
            sig_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
